// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI-slave / single-port RAM subsystem: serialises one
// 10-bit host command per SS_n frame and captures the returned byte for reads.
module spi_master_ctrl #(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cmd_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_GAP
  } state_t;

  localparam logic [3:0] LAST_BIT  = 4'd9;
  localparam logic [3:0] LAST_CAP  = 4'd7;
  localparam logic [3:0] LAST_WAIT = 4'(RD_LAT - 1);
  localparam logic [3:0] LAST_GAP  = 4'(IDLE_GAP - 1);

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic [9:0] shreg;
  logic [7:0] rd_shift;
  logic       is_rd;
  logic       gap_entry;
  logic       ss_n_next, mosi_next, busy_next;

  assign is_rd = (shreg[9:8] == 2'b11);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    next_cnt   = cnt + 4'd1;
    unique case (state)
      S_IDLE:    if (start) next_state = S_SETUP;
      S_SETUP:   next_state = S_CMD;
      S_CMD:     next_state = S_SHIFT;
      S_SHIFT:   if (cnt == LAST_BIT) next_state = is_rd ? S_WAIT : S_GAP;
      S_WAIT:    if (cnt == LAST_WAIT) next_state = S_CAPTURE;
      S_CAPTURE: if (cnt == LAST_CAP) next_state = S_GAP;
      S_GAP:     if (cnt == LAST_GAP) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (next_state != state) next_cnt = 4'd0;
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ss_n_next = (next_state == S_IDLE) || (next_state == S_GAP);
    busy_next = (next_state != S_IDLE);
    gap_entry = (next_state == S_GAP) && (state != S_GAP);
    mosi_next = 1'b0;
    unique case (next_state)
      S_CMD:   mosi_next = shreg[9];
      S_SHIFT: mosi_next = shreg[LAST_BIT - next_cnt];
      default: mosi_next = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      shreg    <= 10'd0;
      rd_shift <= 8'd0;
      rd_data  <= 8'd0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      SS_n     <= ss_n_next;
      MOSI     <= mosi_next;
      busy     <= busy_next;
      done     <= gap_entry;
      rd_valid <= gap_entry && is_rd;
      if (state == S_IDLE && start) shreg <= cmd_word;
      if (state == S_CAPTURE) rd_shift <= {rd_shift[6:0], MISO};
      // The final MISO bit arrives on the same edge that enters GAP.
      if (state == S_CAPTURE && next_state == S_GAP) rd_data <= {rd_shift[6:0], MISO};
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: table-driven frames, random frames
// against a frame-level reference model, reset corner cases and back-to-back.
module tb_spi_master_ctrl;

  localparam int RD_LAT   = 2;
  localparam int IDLE_GAP = 1;
  localparam int GAP3     = 3;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] cmd_word = 10'd0;
  logic       miso = 1'b0;
  logic       busy, done, rd_valid, ss_n, mosi;
  logic [7:0] rd_data;

  logic       g_start = 1'b0;
  logic [9:0] g_cmd = 10'b01_0110_1001;
  logic       g_miso = 1'b0;
  logic       g_busy, g_done, g_rd_valid, g_ss_n, g_mosi;
  logic [7:0] g_rd_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] model_rd = 8'd0;

  spi_master_ctrl #(.RD_LAT(RD_LAT), .IDLE_GAP(IDLE_GAP)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cmd_word(cmd_word),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  spi_master_ctrl #(.RD_LAT(RD_LAT), .IDLE_GAP(GAP3)) u_gap3 (
    .clk(clk), .rst(rst), .start(g_start), .cmd_word(g_cmd),
    .busy(g_busy), .done(g_done), .rd_data(g_rd_data), .rd_valid(g_rd_valid),
    .SS_n(g_ss_n), .MOSI(g_mosi), .MISO(g_miso)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [9:0] cmd;
    logic [7:0] miso_byte;
    bit         poke;
    int         exp_low;
    logic [7:0] exp_rd;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame from an IDLE cycle (entered at posedge+1) and checks every
  // cycle against the frame rules; returns to posedge+1 of an IDLE cycle.
  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] miso_byte,
                           input bit poke, input string tag,
                           output int low_cnt, output int done_cnt);
    bit   rd;
    int   len, cap0;
    logic exp_mosi;
    logic [7:0] exp_rdd;
    rd       = (cmd[9:8] == 2'b11);
    len      = rd ? (12 + RD_LAT + 8) : 12;
    cap0     = 12 + RD_LAT;
    low_cnt  = 0;
    done_cnt = 0;
    start    = 1'b1;
    cmd_word = cmd;
    @(posedge clk); #1;
    start    = 1'b0;
    cmd_word = ~cmd;
    for (int k = 0; k <= len + IDLE_GAP + 1; k++) begin
      if (rd && k >= cap0 && k < cap0 + 8) miso = miso_byte[7 - (k - cap0)];
      else miso = 1'($urandom);
      if (poke && k == 5) begin
        start    = 1'b1;
        cmd_word = 10'h3AA;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 1) exp_mosi = cmd[9];
      else if (k >= 2 && k <= 11) exp_mosi = cmd[11 - k];
      else exp_mosi = 1'b0;
      exp_rdd = (rd && k >= len) ? miso_byte : model_rd;
      check($sformatf("%s k=%0d SS_n", tag, k), 32'(ss_n), 32'(k >= len));
      check($sformatf("%s k=%0d MOSI", tag, k), 32'(mosi), 32'(exp_mosi));
      check($sformatf("%s k=%0d busy", tag, k), 32'(busy), 32'(k < len + IDLE_GAP));
      check($sformatf("%s k=%0d done", tag, k), 32'(done), 32'(k == len));
      check($sformatf("%s k=%0d rd_valid", tag, k), 32'(rd_valid), 32'(rd && k == len));
      check($sformatf("%s k=%0d rd_data", tag, k), 32'(rd_data), 32'(exp_rdd));
      if (ss_n === 1'b0) low_cnt++;
      if (done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    if (rd) model_rd = miso_byte;
  endtask

  initial begin
    int lows_n, dones_n;
    vecs[0] = '{10'b00_1010_0101, 8'h00, 1'b0, 12, 8'h00, "wr_addr"};
    vecs[1] = '{10'b11_0000_0000, 8'hC3, 1'b0, 22, 8'hC3, "rd_data_c3"};
    vecs[2] = '{10'b01_0011_1100, 8'hFF, 1'b1, 12, 8'hC3, "wr_data_poke"};
    vecs[3] = '{10'b10_1111_1111, 8'h00, 1'b0, 12, 8'hC3, "rd_addr"};
    vecs[4] = '{10'b11_1000_0001, 8'h5A, 1'b1, 22, 8'h5A, "rd_data_poke"};
    vecs[5] = '{10'b11_0111_1110, 8'h81, 1'b0, 22, 8'h81, "rd_data_81"};

    // Reset with the clock stopped: outputs must settle asynchronously.
    #3 rst = 1'b1;
    #1;
    check("reset SS_n", 32'(ss_n), 32'd1);
    check("reset MOSI", 32'(mosi), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_frame(vecs[i].cmd, vecs[i].miso_byte, vecs[i].poke, vecs[i].name, lows_n, dones_n);
      check({vecs[i].name, " low cycles"}, 32'(lows_n), 32'(vecs[i].exp_low));
      check({vecs[i].name, " done count"}, 32'(dones_n), 32'd1);
      check({vecs[i].name, " final rd_data"}, 32'(rd_data), 32'(vecs[i].exp_rd));
    end

    // Reset asserted in frame cycle 7 abandons the frame.
    start    = 1'b1;
    cmd_word = 10'b00_0101_0110;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst before SS_n", 32'(ss_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst SS_n", 32'(ss_n), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst MOSI", 32'(mosi), 32'd0);
    check("midrst rd_data", 32'(rd_data), 32'd0);
    model_rd = 8'd0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    lows_n  = 0;
    dones_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ss_n === 1'b0) lows_n++;
      if (done === 1'b1) dones_n++;
    end
    check("midrst no low after", 32'(lows_n), 32'd0);
    check("midrst no done", 32'(dones_n), 32'd0);
    @(posedge clk); #1;
    run_frame(10'b01_1111_0000, 8'h00, 1'b0, "post_rst_wr", lows_n, dones_n);
    check("post_rst_wr low cycles", 32'(lows_n), 32'd12);
    check("post_rst_wr done count", 32'(dones_n), 32'd1);

    // Random frames against the frame-level model.
    for (int n = 0; n < 24; n++) begin
      logic [9:0] rc;
      logic [7:0] rb;
      bit         rp;
      rc = 10'($urandom);
      rb = 8'($urandom);
      rp = 1'($urandom);
      run_frame(rc, rb, rp, $sformatf("rand%0d", n), lows_n, dones_n);
      check($sformatf("rand%0d low cycles", n), 32'(lows_n),
            32'((rc[9:8] == 2'b11) ? 20 + RD_LAT : 12));
      check($sformatf("rand%0d done count", n), 32'(dones_n), 32'd1);
    end

    // Back-to-back on the IDLE_GAP=3 instance with start held high. Between
    // frames SS_n stays high for the gap cycles plus the IDLE acceptance cycle.
    begin
      int   lows[$];
      int   highs[$];
      int   run, g_dones, stray;
      logic prev;
      prev    = 1'b1;
      run     = 0;
      g_dones = 0;
      stray   = 0;
      g_start = 1'b1;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (g_done === 1'b1) begin
          g_dones++;
          if (!(prev === 1'b0 && g_ss_n === 1'b1)) stray++;
        end
        if (g_ss_n === prev) run++;
        else begin
          if (prev) highs.push_back(run);
          else lows.push_back(run);
          run  = 1;
          prev = g_ss_n;
        end
        @(posedge clk); #1;
      end
      g_start = 1'b0;
      check("b2b low runs", 32'(lows.size()), 32'd3);
      check("b2b high runs", 32'(highs.size()), 32'd4);
      foreach (lows[i]) check($sformatf("b2b low run %0d", i), 32'(lows[i]), 32'd12);
      for (int i = 1; i < highs.size(); i++)
        check($sformatf("b2b gap %0d", i), 32'(highs[i]), 32'(GAP3 + 1));
      check("b2b done count", 32'(g_dones), 32'd3);
      check("b2b stray done", 32'(stray), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
